// File: rtl/inst_mem_arbiter.sv
// Instruction-memory arbiter: IF-stage fetch port vs. loader/debug burst port.
// Build option: define ARB_ROUND_ROBIN_EN to alternate priority between loader and fetch on contention.
module inst_mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              stall_req,
  // loader port
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [4:0]        ld_len,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_rvalid,
  output logic              ld_done,
  // memory port
  output logic              mem_ce,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    BURST = 2'd2
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   addr_d;
  logic                we_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   if_inst_q;
  logic                if_valid_q;
  logic [DATA_W-1:0]   ld_rdata_q;
  logic                ld_rvalid_q;
  logic                ld_done_q;

  logic in_burst;
  logic beat;
  logic last_beat;
  logic grant_ld;
  logic grant_if;

  // Zero-length requests become single beats; oversize requests are clamped.
  function automatic logic [CNT_W-1:0] clamp_len(input logic [4:0] len);
    if (len == 5'd0) return CNT_W'(1);
    if (32'(len) > 32'(BURST_MAX)) return CNT_W'(BURST_MAX);
    return CNT_W'(len);
  endfunction

  assign in_burst  = (state_q == BURST);
  assign beat      = in_burst && ld_req;
  assign last_beat = beat && (cnt_q == CNT_W'(1));

`ifdef ARB_ROUND_ROBIN_EN
  logic last_ld_q;
  // On contention the port that did not win last time gets the memory.
  assign grant_ld = !in_burst && ld_req && !(if_req && last_ld_q);
`else
  assign grant_ld = !in_burst && ld_req;
`endif
  assign grant_if = !in_burst && if_req && !grant_ld;

  always_comb begin
    addr_d = addr_q + ADDR_W'(4);
    cnt_d  = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      if_inst_q   <= '0;
      if_valid_q  <= 1'b0;
      ld_rdata_q  <= '0;
      ld_rvalid_q <= 1'b0;
      ld_done_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_ld_q   <= 1'b0;
`endif
    end else begin
      if_valid_q  <= grant_if;
      ld_rvalid_q <= beat && !we_q;
      ld_done_q   <= last_beat;
      if (grant_if)
        if_inst_q <= mem_rdata;
      if (beat && !we_q)
        ld_rdata_q <= mem_rdata;
`ifdef ARB_ROUND_ROBIN_EN
      if (grant_if)
        last_ld_q <= 1'b0;
      else if (last_beat)
        last_ld_q <= 1'b1;
`endif
      case (state_q)
        IDLE, FETCH: begin
          if (grant_ld) begin
            state_q <= BURST;
            addr_q  <= ld_addr;
            we_q    <= ld_we;
            cnt_q   <= clamp_len(ld_len);
          end else if (grant_if) begin
            state_q <= FETCH;
          end else begin
            state_q <= IDLE;
          end
        end
        BURST: begin
          // A cycle without ld_req is a pause and leaves the counters alone.
          if (beat) begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            if (last_beat)
              state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_ce    = !rst && (grant_if || beat);
  assign mem_we    = !rst && beat && we_q;
  assign mem_addr  = in_burst ? addr_q : if_addr;
  assign mem_wdata = ld_wdata;
  assign ld_ready  = !rst && in_burst;
  assign stall_req = !rst && if_req && !grant_if;

  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign ld_rdata  = ld_rdata_q;
  assign ld_rvalid = ld_rvalid_q;
  assign ld_done   = ld_done_q;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Cycle-by-cycle vector bench for inst_mem_arbiter; each record is one clock of inputs and expected outputs.
module tb_inst_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        stall_req;
  logic        ld_req;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [4:0]  ld_len;
  logic [31:0] ld_wdata;
  logic        ld_ready;
  logic [31:0] ld_rdata;
  logic        ld_rvalid;
  logic        ld_done;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  inst_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst), .if_valid(if_valid),
    .stall_req(stall_req),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_len(ld_len),
    .ld_wdata(ld_wdata), .ld_ready(ld_ready), .ld_rdata(ld_rdata),
    .ld_rvalid(ld_rvalid), .ld_done(ld_done),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ifr;
    logic [31:0] ifa;
    logic        ldr, ldwe;
    logic [31:0] lda;
    logic [4:0]  ldl;
    logic [31:0] wd, rd;
    logic        ece, ewe;
    logic [31:0] eaddr;
    logic        estall, eready, eifv;
    logic [31:0] eifi;
    logic        erv;
    logic [31:0] erd;
    logic        edone, dchk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic ifr, input logic [31:0] ifa,
                     input logic ldr, input logic ldwe, input logic [31:0] lda,
                     input logic [4:0] ldl, input logic [31:0] wd, input logic [31:0] rd,
                     input logic ece, input logic ewe, input logic [31:0] eaddr,
                     input logic estall, input logic eready,
                     input logic eifv, input logic [31:0] eifi,
                     input logic erv, input logic [31:0] erd,
                     input logic edone, input logic dchk);
    vec_t v;
    v.rst = r; v.ifr = ifr; v.ifa = ifa; v.ldr = ldr; v.ldwe = ldwe; v.lda = lda;
    v.ldl = ldl; v.wd = wd; v.rd = rd; v.ece = ece; v.ewe = ewe; v.eaddr = eaddr;
    v.estall = estall; v.eready = eready; v.eifv = eifv; v.eifi = eifi;
    v.erv = erv; v.erd = erd; v.edone = edone; v.dchk = dchk;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%08h required=0x%08h", nm, idx, act, exp);
    end
  endtask

  initial begin
    //  rst ifr ifa        ldr we lda           len wd       rd             ce we addr           st rdy ifv ifi           rv rdata       done dchk
    // reset state: combinational outputs forced low even with requests present
    add(1, 1, 32'h0,      1, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 1);
    // fetch only
    add(0, 1, 32'h8,      0, 0, 32'h0,        0, 32'h0,  32'h3C010001,   1, 0, 32'h8,         0, 0,  0, 32'h0,        0, 32'h0,       0, 1);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  1, 32'h3C010001, 0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    // write burst of 4 with a pause, fetch held throughout
    add(0, 1, 32'h20,     1, 1, 32'h100,      4, 32'h0,  32'h0,          0, 0, 32'h0,         1, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h20,     1, 0, 32'h500,      1, 32'hA0, 32'h999,        1, 1, 32'h100,       1, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h20,     0, 0, 32'h0,        0, 32'hEE, 32'h0,          0, 0, 32'h0,         1, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h20,     1, 0, 32'h0,        0, 32'hA1, 32'h0,          1, 1, 32'h104,       1, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h20,     1, 0, 32'h0,        0, 32'hA2, 32'h0,          1, 1, 32'h108,       1, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h20,     1, 0, 32'h0,        0, 32'hA3, 32'h0,          1, 1, 32'h10C,       1, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       1, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    // read burst, ld_len=0 -> one beat
    add(0, 0, 32'h0,      1, 0, 32'h40,       0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      1, 0, 32'h0,        0, 32'h0,  32'h11111111,   1, 0, 32'h40,        0, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        1, 32'h11111111, 1, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    // read burst, ld_len=31 -> clamped to 16 beats
    add(0, 0, 32'h0,      1, 0, 32'h200,     31, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    for (int i = 0; i < 16; i++)
      add(0, 0, 32'h0,    1, 0, 32'h0,        0, 32'h0,  32'hB0000000 + i, 1, 0, 32'h200 + 4*i, 0, 1, 0, 32'h0,      i > 0, 32'hB0000000 + i - 1, 0, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        1, 32'hB000000F, 1, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    // lone fetch, then contention with a 2-beat read burst
    add(0, 1, 32'h10,     0, 0, 32'h0,        0, 32'h0,  32'h77,         1, 0, 32'h10,        0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  1, 32'h77,       0, 32'h0,       0, 0);
    add(0, 1, 32'h30,     1, 0, 32'h300,      2, 32'h0,  32'h0,          0, 0, 32'h0,         1, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h30,     1, 0, 32'h0,        0, 32'h0,  32'hC0,         1, 0, 32'h300,       1, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h30,     1, 0, 32'h0,        0, 32'h0,  32'hC1,         1, 0, 32'h304,       1, 1,  0, 32'h0,        1, 32'hC0,      0, 0);
`ifdef ARB_ROUND_ROBIN_EN
    // burst just finished: fetch wins this contention, loader the next
    add(0, 1, 32'h30,     1, 0, 32'h400,      1, 32'h0,  32'hE0,         1, 0, 32'h30,        0, 0,  0, 32'h0,        1, 32'hC1,      1, 0);
    add(0, 1, 32'h30,     1, 0, 32'h400,      1, 32'h0,  32'h0,          0, 0, 32'h0,         1, 0,  1, 32'hE0,       0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      1, 0, 32'h0,        0, 32'h0,  32'hD0,         1, 0, 32'h400,       0, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        1, 32'hD0,      1, 0);
`else
    // loader keeps priority; fetch only proceeds once ld_req drops
    add(0, 1, 32'h30,     1, 0, 32'h400,      1, 32'h0,  32'h0,          0, 0, 32'h0,         1, 0,  0, 32'h0,        1, 32'hC1,      1, 0);
    add(0, 1, 32'h30,     1, 0, 32'h0,        0, 32'h0,  32'hD0,         1, 0, 32'h400,       1, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h30,     0, 0, 32'h0,        0, 32'h0,  32'hE0,         1, 0, 32'h30,        0, 0,  0, 32'h0,        1, 32'hD0,      1, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  1, 32'hE0,       0, 32'h0,       0, 0);
`endif
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    // reset on beat 2 of a 4-beat write burst
    add(0, 0, 32'h0,      1, 1, 32'h600,      4, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      1, 0, 32'h0,        0, 32'hF0, 32'h0,          1, 1, 32'h600,       0, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(1, 0, 32'h0,      1, 0, 32'h0,        0, 32'hF1, 32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 1, 32'h44,     0, 0, 32'h0,        0, 32'h0,  32'h55,         1, 0, 32'h44,        0, 0,  0, 32'h0,        0, 32'h0,       0, 1);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  1, 32'h55,       0, 32'h0,       0, 0);
    // address wrap
    add(0, 0, 32'h0,      1, 0, 32'hFFFFFFFC, 2, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      1, 0, 32'h0,        0, 32'h0,  32'h1,          1, 0, 32'hFFFFFFFC,  0, 1,  0, 32'h0,        0, 32'h0,       0, 0);
    add(0, 0, 32'h0,      1, 0, 32'h0,        0, 32'h0,  32'h2,          1, 0, 32'h0,         0, 1,  0, 32'h0,        1, 32'h1,       0, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        1, 32'h2,       1, 0);
    add(0, 0, 32'h0,      0, 0, 32'h0,        0, 32'h0,  32'h0,          0, 0, 32'h0,         0, 0,  0, 32'h0,        0, 32'h0,       0, 0);

    rst = 1'b1; if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_we = 1'b0;
    ld_addr = '0; ld_len = '0; ld_wdata = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; if_req = vecs[i].ifr; if_addr = vecs[i].ifa;
      ld_req = vecs[i].ldr; ld_we = vecs[i].ldwe; ld_addr = vecs[i].lda;
      ld_len = vecs[i].ldl; ld_wdata = vecs[i].wd; mem_rdata = vecs[i].rd;
      #1;
      chk("mem_ce", i, 32'(mem_ce), 32'(vecs[i].ece));
      chk("mem_we", i, 32'(mem_we), 32'(vecs[i].ewe));
      if (vecs[i].ece) chk("mem_addr", i, mem_addr, vecs[i].eaddr);
      if (vecs[i].ewe) chk("mem_wdata", i, mem_wdata, vecs[i].wd);
      chk("stall_req", i, 32'(stall_req), 32'(vecs[i].estall));
      chk("ld_ready", i, 32'(ld_ready), 32'(vecs[i].eready));
      chk("if_valid", i, 32'(if_valid), 32'(vecs[i].eifv));
      if (vecs[i].eifv || vecs[i].dchk) chk("if_inst", i, if_inst, vecs[i].eifi);
      chk("ld_rvalid", i, 32'(ld_rvalid), 32'(vecs[i].erv));
      if (vecs[i].erv || vecs[i].dchk) chk("ld_rdata", i, ld_rdata, vecs[i].erd);
      chk("ld_done", i, 32'(ld_done), 32'(vecs[i].edone));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inst_mem_arbiter.md
# inst_mem_arbiter

Shares the single instruction memory between the IF-stage fetch port and a program loader/debug port that moves bursts of words in or out. It drives the memory's chip-enable, write-enable, address and write-data lines. It registers the combinational read data back to whichever port was granted. It stalls the pipeline while the loader owns the memory.

## Interface
- `ADDR_W`, 32, byte address width (matches `InstAddrWidth`)
- `DATA_W`, 32, word width (matches `InstDataWidth`)
- `BURST_MAX`, 16, maximum loader burst length in words
- `clk` in 1: single clock; all state updates on its rising edge
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1: fetch request this cycle
- `if_addr` in ADDR_W: fetch byte address
- `if_inst` out DATA_W: registered fetched word
- `if_valid` out 1: `if_inst` is valid this cycle
- `stall_req` out 1: combinational; high when `if_req` is high and fetch is not granted
- `ld_req` in 1: loader request, also the beat-valid qualifier inside a burst
- `ld_we` in 1: burst direction, 1 = write (sampled at grant)
- `ld_addr` in ADDR_W: burst base byte address (sampled at grant)
- `ld_len` in 5: burst length (sampled at grant)
- `ld_wdata` in DATA_W: write beat data
- `ld_ready` out 1: burst beat slot open
- `ld_rdata` out DATA_W: registered read beat data
- `ld_rvalid` out 1: `ld_rdata` is valid
- `ld_done` out 1: one-cycle pulse when a burst completes
- `mem_ce`, `mem_we` out 1: memory chip-enable and write-enable
- `mem_addr` out ADDR_W: memory byte address; the memory indexes by `addr>>2`
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory combinational read data

## Operation
- FSM states: IDLE, FETCH, BURST. Reset enters IDLE.
- IDLE/FETCH arbitration happens every cycle:
  - `ld_req` high takes priority (subject to the Configuration section). The grant latches `ld_addr` into the address counter, latches `ld_we`, and latches the length into the beat counter. The FSM moves to BURST. There is no memory access in the grant cycle.
  - Otherwise, `if_req` high causes a fetch access: `mem_ce`=1, `mem_we`=0, `mem_addr`=`if_addr`. The FSM moves to FETCH.
  - Otherwise the FSM goes to IDLE and `mem_ce`=0.
- Length rules:
  - `ld_len`=0 is treated as 1.
  - `ld_len`>`BURST_MAX` is clamped to `BURST_MAX`.
- BURST:
  - `ld_ready`=1 throughout.
  - A beat occurs only when `ld_req`=1. A beat drives `mem_ce`=1, `mem_we`=latched we, `mem_addr`=address counter, `mem_wdata`=`ld_wdata`.
  - After each beat the address counter increments by 4 (wraps modulo 2^ADDR_W) and the beat counter decrements.
  - A cycle with `ld_req`=0 is a pause: no access, no counter change, the FSM stays in BURST.
  - The last beat returns the FSM to IDLE. `ld_ready` is low from the next cycle.
- A fetch during BURST is never granted, so `stall_req`=`if_req`.
- `mem_we`=0 in all states except BURST with a write beat.

## Timing
- Read latency is 1 cycle. `mem_rdata` is sampled at the end of the access cycle.
  - For a fetch access, `if_inst` and `if_valid` present the word in the following cycle.
  - For a read beat, `ld_rdata` and `ld_rvalid` present the word in the following cycle.
- `if_valid` and `ld_rvalid` are low in any cycle not following a corresponding access. `if_inst` and `ld_rdata` hold their last value.
- `ld_done` is registered and pulses in the cycle after the last beat. For read bursts it coincides with the last `ld_rvalid`.
- A burst of N beats with no pauses occupies N+1 cycles from grant.
- Reset values: all registered outputs are 0. While `rst`=1, the combinational outputs `mem_ce`, `mem_we`, `ld_ready` and `stall_req` are forced to 0.
- Reset mid-burst: the burst is abandoned, counters are cleared, no `ld_done` is issued, and the FSM is in IDLE on the first cycle after `rst` deasserts.
- Simultaneous `ld_req` and `if_req` in IDLE/FETCH follow the Configuration section.

## Configuration
- `ARB_ROUND_ROBIN_EN` undefined:
  - The loader always has priority.
  - A fetch can be starved by back-to-back bursts.
- `ARB_ROUND_ROBIN_EN` defined:
  - A 1-bit last-grant register alternates priority between loader and fetch when both request in IDLE/FETCH.
  - A completed burst counts as a loader grant, so the next contested cycle goes to fetch.
  - The register resets to "fetch last", so the first contention goes to the loader.

## Test plan
- Fetch only: `if_req`=1, `if_addr`=0x8, `mem_rdata`=0x3C010001 -> same cycle `mem_ce`=1, `mem_addr`=0x8, `stall_req`=0; next cycle `if_inst`=0x3C010001, `if_valid`=1.
- Write burst:
  - Stimulus: grant with `ld_we`=1, `ld_addr`=0x100, `ld_len`=4; data 0xA0..0xA3, with `ld_req` low on the 2nd beat cycle.
  - Response: writes to 0x100, 0x104, 0x108, 0x10C with `mem_we`=1; 6 cycles from grant; `ld_done` one cycle after the last write; `stall_req`=`if_req` throughout.
- Read burst with `ld_len`=0 and with `ld_len`=31: 1 beat and 16 beats respectively; `ld_rvalid` count matches; `ld_done` coincides with the last `ld_rvalid`.
- Contention, macro undefined: `ld_req` and `if_req` both held -> loader granted; fetch stalls until the burst ends. Macro defined: after one 2-beat burst, the next contested cycle grants fetch, then the loader.
- Reset mid-burst: `rst`=1 on beat 2 of 4 -> `mem_ce`=0, `ld_ready`=0, all registered outputs 0, no `ld_done`; after release with `if_req`=1 a fetch is granted immediately.
- Address wrap: read burst at `ld_addr`=0xFFFFFFFC, `ld_len`=2 -> `mem_addr` sequence 0xFFFFFFFC, 0x00000000.
